// File: rtl/execute_memory.sv
// Load/store stage: registers one executed instruction, runs the data-memory
// request/grant/response transaction, and presents one writeback record.
module execute_memory #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        reg_wen_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_wen_o,
  output logic [4:0]  out_rd_o,
  output logic [31:0] out_wdata_o,
  output logic        out_misalign_o,
  output logic        out_bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        accept, is_mem, misaligned, timeout;

  logic [31:0] addr_p0, wdata_p0, result_p0;
  logic [3:0]  wmask_p0;
  logic [1:0]  size_p0;
  logic        we_p0, unsigned_p0;
  logic [4:0]  rd_p0;
  logic        wen_p0, misalign_p0, bus_err_p0;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'd0:    return {4{sd[7:0]}};
      2'd1:    return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    s = rdata >> {off, 3'b000};
    b = $signed(s[7:0]);
    h = $signed(s[15:0]);
    case (size)
      2'd0:    return uns ? {24'h0, s[7:0]}  : 32'(b);
      2'd1:    return uns ? {16'h0, s[15:0]} : 32'(h);
      default: return s;
    endcase
  endfunction

  assign accept     = (state == IDLE) && in_valid_i;
  assign is_mem     = re_i || we_i;
  assign misaligned = is_mem && (((size_i == 2'd1) && addr_i[0]) ||
                                 (size_i[1] && (addr_i[1:0] != 2'b00)));
  assign timeout    = (cnt + 8'd1) == 8'(TIMEOUT_CYCLES);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid_i) state_nxt = (!is_mem || misaligned) ? OUT : REQ;
      REQ:  if (mem_gnt_i) state_nxt = RESP;
      RESP: if (mem_rvalid_i || timeout) state_nxt = OUT;
      OUT:  if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: counter, write enable and error flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt         <= 8'd0;
      wen_p0      <= 1'b0;
      misalign_p0 <= 1'b0;
      bus_err_p0  <= 1'b0;
    end else begin
      if (accept) begin
        cnt         <= 8'd0;
        wen_p0      <= reg_wen_i && !we_i && !misaligned;
        misalign_p0 <= misaligned;
        bus_err_p0  <= 1'b0;
      end else if (state == REQ && mem_gnt_i) begin
        cnt <= 8'd0;
      end else if (state == RESP && !mem_rvalid_i) begin
        cnt <= cnt + 8'd1;
        if (timeout) begin
          bus_err_p0 <= 1'b1;
          wen_p0     <= 1'b0;
        end
      end
    end
  end

  // Data: accepted record and load result, no reset needed
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_p0     <= addr_i;
      we_p0       <= we_i;
      size_p0     <= size_i;
      unsigned_p0 <= unsigned_i;
      rd_p0       <= rd_i;
      wmask_p0    <= we_i ? lane_mask(size_i, addr_i[1:0]) : 4'h0;
      wdata_p0    <= lane_data(size_i, store_data_i);
      result_p0   <= addr_i;
    end else if (state == RESP && mem_rvalid_i && !we_p0) begin
      result_p0 <= load_align(mem_rdata_i, addr_p0[1:0], size_p0, unsigned_p0);
    end
  end

  // Outputs are gated by state so idle/reset values are zero
  assign in_ready_o     = (state == IDLE);
  assign mem_req_o      = (state == REQ);
  assign mem_we_o       = mem_req_o && we_p0;
  assign mem_addr_o     = mem_req_o ? {addr_p0[31:2], 2'b00} : 32'h0;
  assign mem_wmask_o    = mem_req_o ? wmask_p0 : 4'h0;
  assign mem_wdata_o    = mem_req_o ? wdata_p0 : 32'h0;
  assign out_valid_o    = (state == OUT);
  assign out_wen_o      = out_valid_o && wen_p0;
  assign out_rd_o       = out_valid_o ? rd_p0 : 5'd0;
  assign out_wdata_o    = out_valid_o ? result_p0 : 32'h0;
  assign out_misalign_o = out_valid_o && misalign_p0;
  assign out_bus_err_o  = out_valid_o && bus_err_p0;

endmodule

// File: tb/tb_execute_memory.sv
// Scoreboard bench for execute_memory: directed stimulus pushes expected
// writeback records; a negedge monitor pops and compares each delivered record.
module tb_execute_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, re, we, uns, reg_wen;
  logic [1:0]  size;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready, out_wen, out_misalign, out_bus_err;
  logic [4:0]  out_rd;
  logic [31:0] out_wdata;

  always #5 clk = ~clk;

  execute_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .re_i(re), .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr),
    .store_data_i(store_data), .reg_wen_i(reg_wen), .rd_i(rd),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wmask_o(mem_wmask), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_wen_o(out_wen),
    .out_rd_o(out_rd), .out_wdata_o(out_wdata), .out_misalign_o(out_misalign),
    .out_bus_err_o(out_bus_err)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        cw;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t mk(input logic w, input logic [4:0] r, input logic [31:0] d,
                              input logic cw, input logic m, input logic b);
    exp_t e;
    e.wen = w; e.rd = r; e.wdata = d; e.cw = cw; e.mis = m; e.berr = b;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record actual=rd%0d required=none", out_rd);
      end else begin
        e = sbq.pop_front();
        chk("sb_wen", 32'(out_wen), 32'(e.wen));
        chk("sb_rd", 32'(out_rd), 32'(e.rd));
        if (e.cw) chk("sb_wdata", out_wdata, e.wdata);
        chk("sb_misalign", 32'(out_misalign), 32'(e.mis));
        chk("sb_bus_err", 32'(out_bus_err), 32'(e.berr));
      end
    end
  end

  task automatic issue(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] sd, input logic wen,
                       input logic [4:0] d, input logic push, input exp_t e);
    if (push) sbq.push_back(e);
    in_valid = 1'b1; re = r; we = w; size = sz; uns = u;
    addr = a; store_data = sd; reg_wen = wen; rd = d;
    @(posedge clk); #1;
    in_valid = 1'b0; re = 1'b0; we = 1'b0;
  endtask

  task automatic do_bus(input int gdly, input int rdly, input logic [31:0] rdat, input logic give_rv);
    for (int i = 0; i < gdly; i++) begin
      @(posedge clk); #1;
      chk("req_held", 32'(mem_req), 32'd1);
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("req_drop_in_resp", 32'(mem_req), 32'd0);
    if (give_rv) begin
      repeat (rdly) begin @(posedge clk); #1; end
      mem_rvalid = 1'b1; mem_rdata = rdat;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_0000;
      chk("out_valid_after_rvalid", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("back_to_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic bus_chk(input string name, input logic w, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d);
    chk({name, "_req"}, 32'(mem_req), 32'd1);
    chk({name, "_we"}, 32'(mem_we), 32'(w));
    chk({name, "_addr"}, mem_addr, a);
    chk({name, "_wmask"}, 32'(mem_wmask), 32'(m));
    if (w) chk({name, "_wdata"}, mem_wdata, d);
  endtask

  task automatic reset_chk(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_ctl"}, {20'h0, mem_req, mem_we, mem_wmask, out_valid, out_wen, out_misalign, out_bus_err}, 32'h0);
    chk({name, "_rd"}, 32'(out_rd), 32'h0);
    chk({name, "_addr_data"}, mem_addr | mem_wdata | out_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; re = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    addr = 32'h0; store_data = 32'h0; reg_wen = 1'b0; rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_chk("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset during REQ drops the request at once; a late rvalid is ignored
    issue(1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 1, 5'd1, 0, mk(0, 0, 0, 0, 0, 0));
    chk("mid_req_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("mid_req_reset_drop", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_chk("after_reset");
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid_ignored", {30'h0, out_valid, in_ready}, 32'd1);

    // non-memory pass-through, one cycle latency
    issue(0, 0, 2'd0, 0, 32'h1234_5678, 32'h0, 1, 5'd5, 1, mk(1, 5'd5, 32'h1234_5678, 1, 0, 0));
    chk("passthru_latency", 32'(out_valid), 32'd1);
    chk("passthru_no_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // signed byte load from lane 3
    issue(1, 0, 2'd0, 0, 32'h8000_0003, 32'h0, 1, 5'd7, 1, mk(1, 5'd7, 32'hFFFF_FF80, 1, 0, 0));
    bus_chk("lb", 0, 32'h8000_0000, 4'h0, 32'h0);
    do_bus(0, 0, 32'h80FF_0000, 1);
    @(posedge clk); #1; wait_idle();

    // unsigned byte load from lane 3
    issue(1, 0, 2'd0, 1, 32'h8000_0003, 32'h0, 1, 5'd8, 1, mk(1, 5'd8, 32'h0000_0080, 1, 0, 0));
    do_bus(1, 1, 32'h80FF_0000, 1);
    @(posedge clk); #1; wait_idle();

    // signed half load from upper half
    issue(1, 0, 2'd1, 0, 32'h0000_4002, 32'h0, 1, 5'd12, 1, mk(1, 5'd12, 32'hFFFF_8001, 1, 0, 0));
    bus_chk("lh", 0, 32'h0000_4000, 4'h0, 32'h0);
    do_bus(0, 2, 32'h8001_1234, 1);
    @(posedge clk); #1; wait_idle();

    // size 3 behaves as word
    issue(1, 0, 2'd3, 0, 32'h0000_5000, 32'h0, 1, 5'd13, 1, mk(1, 5'd13, 32'hDEAD_BEEF, 1, 0, 0));
    do_bus(0, 0, 32'hDEAD_BEEF, 1);
    @(posedge clk); #1; wait_idle();

    // half store with grant delayed 3 cycles
    issue(0, 1, 2'd1, 0, 32'h0000_2002, 32'h0000_ABCD, 1, 5'd3, 1, mk(0, 5'd3, 32'h0, 0, 0, 0));
    bus_chk("sh", 1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD);
    do_bus(3, 0, 32'h0, 1);
    @(posedge clk); #1; wait_idle();

    // byte store to lane 1, load-and-store both set: store wins
    issue(1, 1, 2'd0, 0, 32'h0000_6001, 32'h1234_5678, 1, 5'd4, 1, mk(0, 5'd4, 32'h0, 0, 0, 0));
    bus_chk("sb", 1, 32'h0000_6000, 4'b0010, 32'h7878_7878);
    do_bus(0, 0, 32'h0, 1);
    @(posedge clk); #1; wait_idle();

    // word store
    issue(0, 1, 2'd2, 0, 32'h0000_600C, 32'hCAFE_F00D, 0, 5'd6, 1, mk(0, 5'd6, 32'h0, 0, 0, 0));
    bus_chk("sw", 1, 32'h0000_600C, 4'hF, 32'hCAFE_F00D);
    do_bus(0, 0, 32'h0, 1);
    @(posedge clk); #1; wait_idle();

    // misaligned word load and misaligned half store: no bus request
    issue(1, 0, 2'd2, 0, 32'h0000_1001, 32'h0, 1, 5'd9, 1, mk(0, 5'd9, 32'h0, 0, 1, 0));
    chk("mis_word_no_req", 32'(mem_req), 32'd0);
    chk("mis_word_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1; wait_idle();
    issue(0, 1, 2'd1, 0, 32'h0000_3003, 32'h0, 1, 5'd10, 1, mk(0, 5'd10, 32'h0, 0, 1, 0));
    chk("mis_half_no_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1; wait_idle();

    // response timeout after 4 RESP cycles, consumer stalls 3 cycles
    out_ready = 1'b0;
    issue(1, 0, 2'd2, 0, 32'h0000_7000, 32'h0, 1, 5'd11, 1, mk(0, 5'd11, 32'h0, 0, 0, 1));
    do_bus(0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("timeout_not_yet", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("timeout_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", {24'h0, out_valid, out_bus_err, out_wen, out_rd}, {24'h0, 3'b110, 5'd11});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_stall_idle", {30'h0, in_ready, out_bus_err}, 32'd2);

    // error flags clear on the next accept
    issue(0, 0, 2'd0, 0, 32'hA5A5_0001, 32'h0, 1, 5'd31, 1, mk(1, 5'd31, 32'hA5A5_0001, 1, 0, 0));
    @(posedge clk); #1; wait_idle();

    begin
      int n = 0;
      while (sbq.size() != 0 && n < 20) begin @(posedge clk); n++; end
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
